// File: rtl/multiplier_datapath.sv
// Shift-and-add multiplier datapath. Holds the multiplicand and a 2*WIDTH
// accumulator whose upper half is the running partial sum and whose lower
// half holds the multiplier bits not yet consumed. Each shift step retires
// one multiplier bit. In two's-complement mode the final step subtracts,
// because the multiplier MSB carries negative weight.
module multiplier_datapath #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic                         clock,
  input  logic                         n_reset,
  input  logic [WIDTH-1:0]             multiplicand,
  input  logic [WIDTH-1:0]             multiplier,
  input  logic                         datapath_do_init,
  input  logic                         datapath_do_shift,
  output logic [2*WIDTH-1:0]           product,
  output logic [$clog2(WIDTH+1)-1:0]   step_count
);

  localparam int             CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  ALL_DONE  = CW'(WIDTH);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH:0] upper_ext;
  logic [WIDTH:0] addend_ext;
  logic [WIDTH:0] sum;
  logic           final_sub;

  // One add/subtract step: extend partial sum and selected addend, then combine.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    upper_ext  = '0;
    addend_ext = '0;
    final_sub  = 1'b0;
    if (SIGNED) begin
      upper_ext = {acc[2*WIDTH-1], acc[2*WIDTH-1:WIDTH]};
      if (acc[0]) addend_ext = {mcand[WIDTH-1], mcand};
      final_sub = (step_count == LAST_STEP);
    end else begin
      upper_ext = {1'b0, acc[2*WIDTH-1:WIDTH]};
      if (acc[0]) addend_ext = {1'b0, mcand};
    end
    sum = final_sub ? (upper_ext - addend_ext) : (upper_ext + addend_ext);
  end

  // Operand load, accumulate-and-shift, and step counting; init beats shift.
  always_ff @(posedge clock or negedge n_reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!n_reset) begin
      mcand      <= '0;
      acc        <= '0;
      step_count <= '0;
    end else if (datapath_do_init) begin
      mcand      <= multiplicand;
      acc        <= {{WIDTH{1'b0}}, multiplier};
      step_count <= '0;
    end else if (datapath_do_shift && (step_count < ALL_DONE)) begin
      acc        <= {sum, acc[WIDTH-1:1]};
      step_count <= step_count + CW'(1);
    end
  end

  assign product = acc;

endmodule
